seq_divider: RTL and testbench

//  Multi-cycle radix-2 restoring divider for the single-cycle CPU's DIV/DIVU/REM/REMU path.
//  It is the subtract-and-shift counterpart to the combinational add/sub datapath.
//  The core stalls on busy and captures quotient/remainder when done pulses.

---
 rtl/seq_divider_if.sv | 34 +++
 rtl/seq_divider.sv | 174 +++++++++++++++++
 tb/tb_seq_divider.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Bundles the divider's request/response signals.
//   master: the requester (CPU core or bench) drives start/flush/operands and
//           observes busy/done/results.
//   slave : the divider itself.
// Handshake: a request is taken on a rising edge where start=1, flush=0 and
// busy=0. busy stays high until and including the single done cycle. Results
// and flags are valid in the done cycle and hold until the next completed
// operation or reset. flush aborts without a done pulse.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, flush, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, flush, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle radix-2 restoring divider (signed/unsigned, quotient
//   truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus_io      seq_divider_if.slave (start/flush/is_signed/dividend/divisor in;
//               busy/done/quotient/remainder/div_zero/overflow out)
//   dbg_state_o current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_if.slave        bus_io,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (magnitude)
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             fast_q, fast_d;   // preset result, skip sign fix-up
  logic             dzp_q, dzp_d;     // pending div_zero
  logic             ovp_q, ovp_d;     // pending overflow
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic             sd, sv, dz_w, ovf_w;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, trial;

  assign sd    = bus_io.is_signed & bus_io.dividend[WIDTH-1];
  assign sv    = bus_io.is_signed & bus_io.divisor[WIDTH-1];
  assign mag_a = sd ? -bus_io.dividend : bus_io.dividend;
  assign mag_b = sv ? -bus_io.divisor  : bus_io.divisor;
  assign dz_w  = (bus_io.divisor == '0);
  assign ovf_w = bus_io.is_signed & (bus_io.dividend == MIN_V) & (&bus_io.divisor);

  // rem < divisor always holds, so the shifted remainder fits in WIDTH+1 bits
  // and the trial difference's top bit is a clean sign.
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr_q};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus_io.start) state_d = (dz_w || ovf_w) ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // flush overrides every transition, including an accept
    if (bus_io.flush) state_d = S_IDLE;
  end

  // Datapath next values
  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    fast_d = fast_q;
    dzp_d  = dzp_q;
    ovp_d  = ovp_q;
    quot_d = quot_q;
    remo_d = remo_q;
    dz_d   = dz_q;
    ov_d   = ov_q;
    case (state_q)
      S_IDLE: begin
        if (bus_io.start && !bus_io.flush) begin
          qneg_d = sd ^ sv;
          rneg_d = sd;
          rem_d  = '0;
          cnt_d  = '0;
          dvd_d  = mag_a;
          dsr_d  = mag_b;
          fast_d = 1'b0;
          dzp_d  = 1'b0;
          ovp_d  = 1'b0;
          if (dz_w) begin
            dvd_d  = '1;
            rem_d  = bus_io.dividend;
            dzp_d  = 1'b1;
            fast_d = 1'b1;
          end else if (ovf_w) begin
            dvd_d  = MIN_V;
            rem_d  = '0;
            ovp_d  = 1'b1;
            fast_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        if (!bus_io.flush) begin
          if (fast_q) begin
            quot_d = dvd_q;
            remo_d = rem_q;
          end else begin
            quot_d = qneg_q ? -dvd_q : dvd_q;
            remo_d = rneg_q ? -rem_q : rem_q;
          end
          dz_d = dzp_q;
          ov_d = ovp_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      fast_q  <= 1'b0;
      dzp_q   <= 1'b0;
      ovp_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      fast_q  <= fast_d;
      dzp_q   <= dzp_d;
      ovp_q   <= ovp_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign bus_io.busy      = (state_q != S_IDLE);
  assign bus_io.done      = (state_q == S_DONE);
  assign bus_io.quotient  = quot_q;
  assign bus_io.remainder = remo_q;
  assign bus_io.div_zero  = dz_q;
  assign bus_io.overflow  = ov_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) dut_if ();

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_io     (dut_if),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [W-1:0] last_q = '0, last_r = '0;
  logic         last_dz = 1'b0, last_ov = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic from the division rules.
  function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov, output int lat);
    longint sa, sb, tq, tr;
    longint unsigned ua, ub, uq, ur;
    dz = 1'b0; ov = 1'b0; lat = W + 2;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 2;
    end else if (sgn && a == MIN_V && b == '1) begin
      q = MIN_V; r = '0; ov = 1'b1; lat = 2;
    end else if (sgn) begin
      sa = {{32{a[W-1]}}, a};
      sb = {{32{b[W-1]}}, b};
      tq = sa / sb;
      tr = sa % sb;
      q = tq[W-1:0];
      r = tr[W-1:0];
    end else begin
      ua = {32'b0, a};
      ub = {32'b0, b};
      uq = ua / ub;
      ur = ua % ub;
      q = uq[W-1:0];
      r = ur[W-1:0];
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Starts an operation in the next cycle (cycle 0), optionally re-pulses start
  // with junk operands in cycle repulse_at, optionally raises start during done.
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int repulse_at, input bit start_at_done);
    logic [W-1:0] eq, er;
    logic edz, eov;
    int lat, n, busy_bad;
    bit got;
    model(sgn, a, b, eq, er, edz, eov, lat);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    @(posedge clk); #1;
    dut_if.start = 1'b1; dut_if.is_signed = sgn; dut_if.dividend = a; dut_if.divisor = b;
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    dut_if.dividend = $urandom; dut_if.divisor = $urandom; dut_if.is_signed = 1'($urandom);
    n = 0; got = 0; busy_bad = 0;
    while (!got && n < 60) begin
      n++;
      @(negedge clk);
      if (dut_if.done) got = 1;
      else begin
        if (!dut_if.busy) busy_bad++;
        if (n == repulse_at) begin
          dut_if.start = 1'b1;
          dut_if.dividend = $urandom;
          dut_if.divisor = $urandom_range(1, 5);
        end else dut_if.start = 1'b0;
      end
    end
    dut_if.start = 1'b0;
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    chk("done_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("latency", 32'(n), 32'(lat));
    chk("busy_until_done", 32'(busy_bad), 32'd0);
    chk("busy_in_done", 32'(dut_if.busy), 32'd1);
    chk("quotient", dut_if.quotient, eq);
    chk("remainder", dut_if.remainder, er);
    chk("div_zero", 32'(dut_if.div_zero), 32'(edz));
    chk("overflow", 32'(dut_if.overflow), 32'(eov));
    last_q = eq; last_r = er; last_dz = edz; last_ov = eov;
    if (start_at_done) begin
      dut_if.start = 1'b1; dut_if.dividend = 32'd7; dut_if.divisor = 32'd1;
      @(posedge clk); #1;
      dut_if.start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", 32'(dut_if.busy), 32'd0);
      chk("done_one_cycle", 32'(dut_if.done), 32'd0);
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dut_if.done) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  task automatic flush_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    dut_if.start = 1'b1; dut_if.is_signed = 1'b0; dut_if.dividend = a; dut_if.divisor = b;
    @(posedge clk); #1;                 // cycle 1
    dut_if.start = 1'b0;
    repeat (9) @(posedge clk);          // cycle 10
    #1 dut_if.flush = 1'b1;
    @(posedge clk); #1;
    dut_if.flush = 1'b0;
    @(negedge clk);                     // cycle 11
    chk("flush_busy", 32'(dut_if.busy), 32'd0);
    chk("flush_done", 32'(dut_if.done), 32'd0);
    chk("flush_keep_q", dut_if.quotient, last_q);
    chk("flush_keep_r", dut_if.remainder, last_r);
    chk("flush_keep_dz", 32'(dut_if.div_zero), 32'(last_dz));
    chk("flush_keep_ov", 32'(dut_if.overflow), 32'(last_ov));
    watch_no_done("flush_no_done", 40);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(dut_if.busy), 32'd0);
    chk({tag, "_done"}, 32'(dut_if.done), 32'd0);
    chk({tag, "_q"}, dut_if.quotient, 32'd0);
    chk({tag, "_r"}, dut_if.remainder, 32'd0);
    chk({tag, "_dz"}, 32'(dut_if.div_zero), 32'd0);
    chk({tag, "_ov"}, 32'(dut_if.overflow), 32'd0);
  endtask

  task automatic reset_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    dut_if.start = 1'b1; dut_if.is_signed = 1'b0; dut_if.dividend = a; dut_if.divisor = b;
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    repeat (9) @(posedge clk);          // cycle 10
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    last_q = '0; last_r = '0; last_dz = 1'b0; last_ov = 1'b0;
    watch_no_done("rst_no_done", 40);
    check_zero("after_rst");
  endtask

  task automatic rand_ops(input int count);
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < count; i++) begin
      s = 1'($urandom);
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = MIN_V;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = '1;
        2, 3:    b = $urandom_range(1, 15);
        4:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(s, a, b, 0, 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    dut_if.start = 1'b0; dut_if.flush = 1'b0; dut_if.is_signed = 1'b0;
    dut_if.dividend = '0; dut_if.divisor = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);      // back-to-back accept
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_op(1'b0, 32'h1234, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'd0, 0, 1'b0);     // div_zero wins over MIN
    run_op(1'b1, MIN_V, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b0, MIN_V, 32'hFFFF_FFFF, 0, 1'b0);     // clears overflow flag
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(1'b0, 32'd1000, 32'd3, 5, 1'b1);           // re-pulse and start-in-done ignored
    run_op(1'b1, 32'h7FFF_FFFF, MIN_V, 0, 1'b0);

    flush_op(32'd555, 32'd11);
    rand_ops(20);

    reset_op(32'd999, 32'd4);
    rand_ops(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end
endmodule
